// File: rtl/multicycle_datapath.sv
// Multi-cycle ARM-subset datapath: one shared memory port, IR/Data/A/WriteData/ALUOut staging
// registers, a register file whose top index aliases PC+4, and a global stall.
module multicycle_datapath #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            Stall,
  output logic [XLEN-1:0] Adr,
  output logic [XLEN-1:0] WriteData,
  input  logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] Instr,
  output logic [3:0]      ALUFlags,
  input  logic            PCWrite,
  input  logic            AdrSrc,
  input  logic            IRWrite,
  input  logic            RegWrite,
  input  logic [1:0]      RegSrc,
  input  logic [1:0]      ImmSrc,
  input  logic            ALUSrcA,
  input  logic [1:0]      ALUSrcB,
  input  logic [1:0]      ALUCtrl,
  input  logic [1:0]      ResultSrc
);

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR}        alu_op_e;
  typedef enum logic [1:0] {IMM_8, IMM_12, IMM_24, IMM_ZERO}           imm_e;
  typedef enum logic [1:0] {SRCB_WD, SRCB_IMM, SRCB_FOUR, SRCB_ZERO}   srcb_e;
  typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALU, RES_ALUOUT_ALT} res_e;

  localparam logic [3:0] PC_IDX = 4'(NREG - 1);

  // Architectural and inter-step state.
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] data_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] wd_reg;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] gpr [NREG-1];

  // Instruction fields are taken from a 64-bit view so narrow XLEN builds still see bits 23:0.
  logic [63:0] ir_wide;
  logic [3:0]  rn_idx, rd_idx, rm_idx;
  logic [3:0]  ra1, ra2;
  logic        unused_ir;

  assign ir_wide   = 64'(ir);
  assign rn_idx    = ir_wide[19:16];
  assign rd_idx    = ir_wide[15:12];
  assign rm_idx    = ir_wide[3:0];
  assign unused_ir = ^ir_wide[63:24];

  assign ra1 = RegSrc[0] ? PC_IDX : rn_idx;
  assign ra2 = RegSrc[1] ? rd_idx : rm_idx;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] rd1, rd2;

  assign pc_plus4 = pc + XLEN'(4);

  // NOTE: every signal written in an always_comb gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    rd1 = '0;
    if (ra1 == PC_IDX)             rd1 = pc_plus4;
    else if (int'(ra1) < NREG - 1) rd1 = gpr[ra1];
  end

  always_comb begin
    rd2 = '0;
    if (ra2 == PC_IDX)             rd2 = pc_plus4;
    else if (int'(ra2) < NREG - 1) rd2 = gpr[ra2];
  end

  logic [XLEN-1:0] ext_imm;

  // imm24 is a word offset: sign-extend, scale by 4, then truncate to the datapath width.
  always_comb begin
    ext_imm = '0;
    unique case (imm_e'(ImmSrc))
      IMM_8:    ext_imm = XLEN'(ir_wide[7:0]);
      IMM_12:   ext_imm = XLEN'(ir_wide[11:0]);
      IMM_24:   ext_imm = XLEN'({{40{ir_wide[23]}}, ir_wide[23:0], 2'b00});
      IMM_ZERO: ext_imm = '0;
      default:  ext_imm = '0;
    endcase
  end

  logic [XLEN-1:0] src_a, src_b;

  assign src_a = ALUSrcA ? pc : a_reg;

  always_comb begin
    src_b = '0;
    unique case (srcb_e'(ALUSrcB))
      SRCB_WD:   src_b = wd_reg;
      SRCB_IMM:  src_b = ext_imm;
      SRCB_FOUR: src_b = XLEN'(4);
      SRCB_ZERO: src_b = '0;
      default:   src_b = '0;
    endcase
  end

  alu_op_e         alu_op;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] alu_result;
  logic            carry, ovf;

  assign alu_op = alu_op_e'(ALUCtrl);
  assign b_eff  = (alu_op == ALU_SUB) ? ~src_b : src_b;
  assign sum    = {1'b0, src_a} + {1'b0, b_eff} + (XLEN+1)'(alu_op == ALU_SUB);

  always_comb begin
    alu_result = sum[XLEN-1:0];
    carry      = 1'b0;
    ovf        = 1'b0;
    unique case (alu_op)
      ALU_ADD, ALU_SUB: begin
        carry = sum[XLEN];
        ovf   = (src_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
      end
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      default: alu_result = sum[XLEN-1:0];
    endcase
  end

  assign ALUFlags = {alu_result[XLEN-1], alu_result == '0, carry, ovf};

  logic [XLEN-1:0] result;

  always_comb begin
    result = alu_out;
    unique case (res_e'(ResultSrc))
      RES_ALUOUT:     result = alu_out;
      RES_DATA:       result = data_reg;
      RES_ALU:        result = alu_result;
      RES_ALUOUT_ALT: result = alu_out;
      default:        result = alu_out;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc;
  assign WriteData = wd_reg;
  assign Instr     = ir;

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values; the fetch relies on IR taking ReadData from the old PC while PC advances.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      data_reg <= '0;
      a_reg    <= '0;
      wd_reg   <= '0;
      alu_out  <= '0;
      // NOTE: the register file is reset explicitly because software may rely on zeroed GPRs;
      // this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NREG - 1; i++) gpr[i] <= '0;
    end else if (!Stall) begin
      data_reg <= ReadData;
      a_reg    <= rd1;
      wd_reg   <= rd2;
      alu_out  <= alu_result;
      if (IRWrite) ir <= ReadData;
      if (PCWrite) pc <= result;
      // The PC alias is read-only through the register file; only PCWrite moves the PC.
      if (RegWrite && int'(rd_idx) < NREG - 1) gpr[rd_idx] <= result;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed steps from the datapath's documented scenarios,
// then random control sequences checked against a behavioural model of the datapath.
module tb_multicycle_datapath;

  logic        clk;
  logic        Reset;
  logic        Stall;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUCtrl, ResultSrc;

  multicycle_datapath #(.XLEN(32), .NREG(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .Reset(Reset), .Stall(Stall), .Adr(Adr), .WriteData(WriteData),
    .ReadData(ReadData), .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegSrc(RegSrc),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
    .ResultSrc(ResultSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall;
    logic       pcw;
    logic       adrsrc;
    logic       irw;
    logic       regw;
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aluctrl;
    logic [1:0] rsrc;
  } ctl_t;

  int errors = 0;
  int checks = 0;

  // Behavioural view of the architectural state.
  logic [31:0] m_pc, m_ir, m_data, m_a, m_wd, m_aluout;
  logic [31:0] m_gpr [15];

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ir = '0; m_data = '0; m_a = '0; m_wd = '0; m_aluout = '0;
    foreach (m_gpr[i]) m_gpr[i] = '0;
  endtask

  function automatic logic [31:0] rreg(input logic [3:0] k);
    return (k == 4'd15) ? m_pc + 32'd4 : m_gpr[k];
  endfunction

  function automatic logic [31:0] ext_imm();
    int s;
    s = $signed(m_ir[23:0]);
    case (ImmSrc)
      2'd0:    return {24'd0, m_ir[7:0]};
      2'd1:    return {20'd0, m_ir[11:0]};
      2'd2:    return 32'(s * 4);
      default: return 32'h0;
    endcase
  endfunction

  // Arithmetic done on 64-bit integers: carry and overflow fall out of range tests.
  function automatic void model_comb(output logic [31:0] r, output logic [3:0] f,
                                     output logic [31:0] res);
    logic [31:0] x, y;
    longint ux, uy, sx, sy, t;
    logic c, v;
    x = ALUSrcA ? m_pc : m_a;
    case (ALUSrcB)
      2'd0:    y = m_wd;
      2'd1:    y = ext_imm();
      2'd2:    y = 32'd4;
      default: y = 32'd0;
    endcase
    ux = longint'(x); uy = longint'(y);
    sx = longint'($signed(x)); sy = longint'($signed(y));
    c = 1'b0; v = 1'b0;
    case (ALUCtrl)
      2'd0: begin
        r = x + y;
        c = (ux + uy) > longint'(32'hFFFF_FFFF);
        t = sx + sy; v = (t > SMAX) || (t < SMIN);
      end
      2'd1: begin
        r = x - y;
        c = ux >= uy;
        t = sx - sy; v = (t > SMAX) || (t < SMIN);
      end
      2'd2:    r = x & y;
      default: r = x | y;
    endcase
    f = {r[31], r == 32'h0, c, v};
    case (ResultSrc)
      2'd1:    res = m_data;
      2'd2:    res = r;
      default: res = m_aluout;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] r, res, na, nwd;
    logic [3:0]  f, ra1, ra2, rdi;
    if (Stall) return;
    model_comb(r, f, res);
    ra1 = RegSrc[0] ? 4'd15 : m_ir[19:16];
    ra2 = RegSrc[1] ? m_ir[15:12] : m_ir[3:0];
    rdi = m_ir[15:12];
    na  = rreg(ra1);
    nwd = rreg(ra2);
    if (RegWrite && rdi != 4'd15) m_gpr[rdi] = res;
    if (PCWrite) m_pc = res;
    if (IRWrite) m_ir = ReadData;
    m_data = ReadData; m_a = na; m_wd = nwd; m_aluout = r;
  endtask

  task automatic drive(input ctl_t c, input logic [31:0] rd);
    Stall = c.stall; PCWrite = c.pcw; AdrSrc = c.adrsrc; IRWrite = c.irw;
    RegWrite = c.regw; RegSrc = c.regsrc; ImmSrc = c.immsrc; ALUSrcA = c.asa;
    ALUSrcB = c.asb; ALUCtrl = c.aluctrl; ResultSrc = c.rsrc; ReadData = rd;
  endtask

  // Drive on the falling edge, then compare every output against the model before the rise.
  task automatic apply(input ctl_t c, input logic [31:0] rd);
    logic [31:0] r, res;
    logic [3:0]  f;
    @(negedge clk);
    drive(c, rd);
    #1;
    model_comb(r, f, res);
    check("adr",    Adr,            AdrSrc ? res : m_pc);
    check("flags",  32'(ALUFlags),  32'(f));
    check("instr",  Instr,          m_ir);
    check("wdata",  WriteData,      m_wd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input ctl_t c, input logic [31:0] rd);
    apply(c, rd);
    tick();
  endtask

  ctl_t c;

  initial begin
    Reset = 1'b0;
    drive('0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_adr",   Adr,       32'h0);
    check("rst_instr", Instr,     32'h0);
    check("rst_wdata", WriteData, 32'h0);
    c = '0; apply(c, 32'h0); Reset = 1'b1; tick();

    // Fetch: IR takes the word at the old PC while PC advances by 4.
    c = '0; c.pcw = 1'b1; c.irw = 1'b1; c.asa = 1'b1; c.asb = 2'd2; c.rsrc = 2'd2;
    step(c, 32'hE3A0_1005);
    check("fetch_instr", Instr, 32'hE3A0_1005);
    check("fetch_pc",    Adr,   32'h4);

    // Add-immediate into R1, with a same-register read on the write edge.
    c = '0; c.asb = 2'd1; c.rsrc = 2'd2; step(c, 32'h0);
    c = '0; c.regw = 1'b1; c.regsrc = 2'd2; step(c, 32'h0);
    check("rdw_old_value", WriteData, 32'h0);
    c = '0; c.regsrc = 2'd2; step(c, 32'h0);
    check("addi_r1", WriteData, 32'h5);

    // Flags: 0x7FFFFFFF + 1 overflows into the sign bit.
    c = '0; c.irw = 1'b1; step(c, 32'hE082_2001);
    c = '0; step(c, 32'h7FFF_FFFF);
    c = '0; c.regw = 1'b1; c.rsrc = 2'd1; step(c, 32'h0);
    c = '0; step(c, 32'h0);
    c = '0; c.asb = 2'd1; apply(c, 32'h0);
    check("flags_add_ovf", 32'(ALUFlags), 32'b1001);
    tick();

    // Flags: 5 - 5 is zero with no borrow.
    c = '0; step(c, 32'h5);
    c = '0; c.regw = 1'b1; c.rsrc = 2'd1; step(c, 32'h0);
    c = '0; step(c, 32'h0);
    c = '0; c.aluctrl = 2'd1; apply(c, 32'h0);
    check("flags_sub_zero", 32'(ALUFlags), 32'b0110);
    tick();

    // Load: address from ALUOut, data lands in R3 two edges later.
    c = '0; c.irw = 1'b1; step(c, 32'hE590_3100);
    c = '0; step(c, 32'h0);
    c = '0; c.immsrc = 2'd1; c.asb = 2'd1; step(c, 32'h0);
    c = '0; c.adrsrc = 1'b1; apply(c, 32'hDEAD_BEEF);
    check("load_adr", Adr, 32'h100);
    tick();
    c = '0; c.regw = 1'b1; c.rsrc = 2'd1; step(c, 32'h0);
    c = '0; c.regsrc = 2'd2; step(c, 32'h0);
    check("load_r3", WriteData, 32'hDEAD_BEEF);

    // Stall during a fetch with every enable high.
    c = '0; c.stall = 1'b1; c.pcw = 1'b1; c.irw = 1'b1; c.regw = 1'b1;
    c.asa = 1'b1; c.asb = 2'd2; c.rsrc = 2'd2;
    repeat (3) begin
      step(c, 32'hE3A0_2007);
      check("stall_pc", Adr,   32'h4);
      check("stall_ir", Instr, 32'hE590_3100);
    end
    c = '0; c.regsrc = 2'd2; step(c, 32'h0);
    check("stall_r3", WriteData, 32'hDEAD_BEEF);
    c = '0; c.pcw = 1'b1; c.irw = 1'b1; c.asa = 1'b1; c.asb = 2'd2; c.rsrc = 2'd2;
    step(c, 32'hE3A0_2007);
    check("release_ir", Instr, 32'hE3A0_2007);
    check("release_pc", Adr,   32'h8);

    // Reset between edges with a register and PC write pending.
    c = '0; c.regw = 1'b1; c.pcw = 1'b1; c.asa = 1'b1; c.asb = 2'd2; c.rsrc = 2'd2;
    apply(c, 32'h0);
    Reset = 1'b0;
    #1;
    model_reset();
    check("midrst_pc",    Adr,       32'h0);
    check("midrst_instr", Instr,     32'h0);
    check("midrst_wdata", WriteData, 32'h0);
    c = '0; apply(c, 32'h0); Reset = 1'b1; tick();

    // R1 was cleared; R15 writes are dropped and R15 reads see PC+4.
    c = '0; c.irw = 1'b1; step(c, 32'hE3A0_F001);
    c = '0; step(c, 32'h0);
    check("midrst_r1", WriteData, 32'h0);
    c = '0; c.regw = 1'b1; c.asa = 1'b1; c.asb = 2'd2; c.rsrc = 2'd2; step(c, 32'h0);
    check("r15_write_ignored", Adr, 32'h0);
    c = '0; c.regsrc = 2'd2; step(c, 32'h0);
    check("r15_alias", WriteData, 32'h4);

    // Random control sequences against the model.
    for (int n = 0; n < 400; n++) begin
      c.stall   = ($urandom_range(7) == 0);
      c.pcw     = ($urandom_range(3) == 0);
      c.adrsrc  = 1'($urandom);
      c.irw     = ($urandom_range(3) == 0);
      c.regw    = 1'($urandom);
      c.regsrc  = 2'($urandom);
      c.immsrc  = 2'($urandom);
      c.asa     = 1'($urandom);
      c.asb     = 2'($urandom);
      c.aluctrl = 2'($urandom);
      c.rsrc    = 2'($urandom);
      step(c, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
